ram_rd_check: RTL and testbench
===============================

# ram_rd_check

Read-side controller for the 64-entry dual-port RAM demo. It waits for the write side's `rd_flag`, then continuously sweeps read port B over addresses 0..63, one address per clock, with wrap-around. Returned data is checked against the write-side pattern `{2'b0, addr}`. The block exposes per-word valid and data, a pass-complete pulse, and sticky and counted error status for on-board debug (ILA or LEDs).

## Interface
- `RD_LAT`, default 1: RAM port-B read latency in cycles; legal values are 1 and 2.
- `ERR_W`, default 8: width of the error counter and the pass counter.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `rd_flag`  input  1  from the write side; goes high once addresses 0..31 are written, then stays high.
- `ram_rd_en`  output  1  port-B enable.
- `ram_rd_addr`  output  6  port-B address.
- `ram_rd_data`  input  8  port-B read data.
- `rd_valid`  output  1  `rd_data_q` holds a checked word this cycle.
- `rd_data_q`  output  8  captured read data.
- `rd_addr_q`  output  6  address that belongs to `rd_data_q`.
- `pass_done`  output  1  one-cycle pulse when the word for address 63 is checked.
- `pass_cnt`  output  `ERR_W`  number of completed passes; saturates at all-ones.
- `err`  output  1  sticky; set on the first mismatch, cleared only by `rst`.
- `err_cnt`  output  `ERR_W`  number of mismatched words; saturates at all-ones.

## Operation
- FSM has three states: IDLE, RUN, DRAIN.
- **IDLE**
  - `ram_rd_en` = 0 and `ram_rd_addr` = 0.
  - When `rd_flag` is sampled high, go to RUN.
- **RUN**
  - `ram_rd_en` = 1.
  - `ram_rd_addr` increments by 1 every cycle, wrapping 63 -> 0 (6-bit natural wrap).
  - When `rd_flag` is sampled low, go to DRAIN, drop `ram_rd_en`, and hold the address.
- **DRAIN**
  - Issue no new reads.
  - Wait exactly `RD_LAT` cycles so in-flight words are still checked, then go to IDLE with the address reset to 0.
  - If `rd_flag` is high when DRAIN completes, go to IDLE anyway. The next cycle re-enters RUN starting at address 0.
- **Request pipeline**
  - A shift register of depth `RD_LAT` carries `{issue_valid, addr}`, where `issue_valid` = `ram_rd_en`.
  - The stage that lines up with `ram_rd_data` drives the checker.
- **Checker** (acts when the aligned stage is valid)
  - Capture `rd_data_q` <= `ram_rd_data` and `rd_addr_q` <= the aligned address.
  - Assert `rd_valid` for one cycle.
  - Mismatch means `ram_rd_data` != `{2'b0, aligned addr}`. On a mismatch, set `err` and increment `err_cnt` (saturating).
  - If the aligned address is 63, pulse `pass_done` and increment `pass_cnt` (saturating).
- Both counters are unsigned `ERR_W`-bit values; once at all-ones they hold.
- Because the reader starts 32 addresses behind the writer and both advance one per cycle, it never reads an address in the same cycle it is written. The block does not check for collisions.

## Timing
- **Reset values (asynchronous on `rst` high):**
  - state = IDLE
  - `ram_rd_en` = 0, `ram_rd_addr` = 0
  - pipeline valid bits = 0
  - `rd_valid` = 0, `rd_data_q` = 0, `rd_addr_q` = 0
  - `pass_done` = 0, `pass_cnt` = 0
  - `err` = 0, `err_cnt` = 0
- **Start:** `rd_flag` is first sampled high at edge N. Then `ram_rd_en` = 1 and `ram_rd_addr` = 0 during cycle N+1.
- **Read latency:** `ram_rd_data` for a request driven in cycle t is valid in cycle t+`RD_LAT`.
- **Checker latency:**
  - `rd_valid`, `rd_data_q` and `rd_addr_q` update at the end of cycle t+`RD_LAT`, so they are visible in cycle t+`RD_LAT`+1.
  - `err`, `err_cnt`, `pass_done` and `pass_cnt` are registered in that same cycle.
- **Throughput in RUN:** one check per cycle. `rd_valid` stays continuously high from cycle N+2+`RD_LAT` onward.
- **Drain:** after `rd_flag` is sampled low, exactly `RD_LAT` more `rd_valid` pulses follow, then `rd_valid` stays 0.
- **Reset mid-pass:** all state clears immediately and asynchronously. No partial `pass_done` is emitted. After `rst` deasserts, the block waits for `rd_flag` again.
- **Simultaneous events:** if a mismatch happens on address 63, `err_cnt` and `pass_cnt` both increment in the same cycle.

## Test plan
- Reset, then hold `rd_flag` = 0 for 20 cycles -> `ram_rd_en` = 0, `rd_valid` = 0, all counters 0.
- Model the RAM with `RD_LAT` = 1, preload `{2'b0, a}` at every address a, raise `rd_flag` at edge 10 -> addresses 0,1,2,... from cycle 11; first `rd_valid` in cycle 13 with `rd_data_q` = 0x00; after 64 checks, `pass_done` pulses with `rd_addr_q` = 63; `pass_cnt` = 1; `err` = 0.
- Run 3 passes with `RD_LAT` = 2 -> address wraps 63 -> 0 without gaps; `pass_cnt` = 3; `rd_valid` high continuously; `err_cnt` = 0.
- Corrupt address 17 to 0xFF -> `err` = 1 and `err_cnt` increments once per pass, with `rd_addr_q` = 17 on the mismatch cycle; corrupt address 63 as well -> `err_cnt` and `pass_cnt` increment in the same cycle.
- Drop `rd_flag` mid-pass at address 40 -> `ram_rd_en` falls, `RD_LAT` trailing checks occur, state returns to IDLE, `ram_rd_addr` = 0; re-raising `rd_flag` restarts at address 0.
- Assert `rst` in RUN at address 25 -> outputs clear asynchronously within the same cycle; force `err_cnt` toward saturation by corrupting all 64 words for 5 passes with `ERR_W` = 8 -> `err_cnt` holds at 255.

Source files
------------

// File: rtl/ram_rd_check.sv
// rtl/ram_rd_check.sv - port-B read sweeper and data checker for the 64-entry dual-port RAM demo
// Sweeps addresses 0..63 after rd_flag, checks data == {2'b0, addr}, reports passes and errors.
module ram_rd_check #(
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_flag,
    output logic             o_ram_rd_en,
    output logic [5:0]       o_ram_rd_addr,
    input  logic [7:0]       i_ram_rd_data,
    output logic             o_rd_valid,
    output logic [7:0]       o_rd_data_q,
    output logic [5:0]       o_rd_addr_q,
    output logic             o_pass_done,
    output logic [ERR_W-1:0] o_pass_cnt,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [ERR_W-1:0] CNT_ONE    = 1;
    localparam logic [ERR_W-1:0] CNT_MAX    = '1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_addr;
    logic [5:0] w_addr_nxt;
    logic [1:0] r_drain_cnt;
    logic [1:0] w_drain_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 6'd0;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            S_IDLE: begin
                w_addr_nxt = 6'd0;
                if (i_rd_flag) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (i_rd_flag) begin
                    w_addr_nxt = r_addr + 6'd1;
                end else begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = 2'd0;
                end
            end
            S_DRAIN: begin
                // Stay long enough for every in-flight word to reach the checker.
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt     = S_IDLE;
                    w_addr_nxt      = 6'd0;
                    w_drain_cnt_nxt = 2'd0;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 6'd0;
            end
        endcase
    end

    assign o_ram_rd_en   = (r_state == S_RUN);
    assign o_ram_rd_addr = r_addr;

    logic [RD_LAT-1:0] r_pipe_vld;
    logic [5:0]        r_pipe_addr [RD_LAT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_addr[i] <= 6'd0;
            end
        end else begin
            r_pipe_vld[0]  <= o_ram_rd_en;
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    logic       w_chk_vld;
    logic [5:0] w_chk_addr;
    logic       w_mismatch;
    logic       w_last;

    assign w_chk_vld  = r_pipe_vld[RD_LAT-1];
    assign w_chk_addr = r_pipe_addr[RD_LAT-1];
    assign w_mismatch = (i_ram_rd_data != {2'b00, w_chk_addr});
    assign w_last     = (w_chk_addr == 6'd63);

    logic             r_rd_valid;
    logic [7:0]       r_rd_data_q;
    logic [5:0]       r_rd_addr_q;
    logic             r_pass_done;
    logic [ERR_W-1:0] r_pass_cnt;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_data_q <= 8'd0;
            r_rd_addr_q <= 6'd0;
            r_pass_done <= 1'b0;
            r_pass_cnt  <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_rd_valid  <= w_chk_vld;
            r_pass_done <= w_chk_vld && w_last;
            if (w_chk_vld) begin
                r_rd_data_q <= i_ram_rd_data;
                r_rd_addr_q <= w_chk_addr;
                if (w_mismatch) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != CNT_MAX) begin
                        r_err_cnt <= r_err_cnt + CNT_ONE;
                    end
                end
                if (w_last && (r_pass_cnt != CNT_MAX)) begin
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data_q = r_rd_data_q;
    assign o_rd_addr_q = r_rd_addr_q;
    assign o_pass_done = r_pass_done;
    assign o_pass_cnt  = r_pass_cnt;
    assign o_err       = r_err;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ram_rd_check.sv
// tb/tb_ram_rd_check.sv - bench for ram_rd_check at RD_LAT 1 and 2 against a cycle-count reference model
module tb_ram_rd_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_flag;
    logic       rd_en     [2];
    logic [5:0] rd_addr   [2];
    logic [7:0] rd_data   [2];
    logic       rd_valid  [2];
    logic [7:0] rd_data_q [2];
    logic [5:0] rd_addr_q [2];
    logic       pass_done [2];
    logic [7:0] pass_cnt  [2];
    logic       err       [2];
    logic [7:0] err_cnt   [2];

    always #5 clk = ~clk;

    ram_rd_check #(.RD_LAT(1), .ERR_W(8)) u_dut_l1 (
        .i_clk(clk), .i_rst(rst), .i_rd_flag(rd_flag),
        .o_ram_rd_en(rd_en[0]), .o_ram_rd_addr(rd_addr[0]), .i_ram_rd_data(rd_data[0]),
        .o_rd_valid(rd_valid[0]), .o_rd_data_q(rd_data_q[0]), .o_rd_addr_q(rd_addr_q[0]),
        .o_pass_done(pass_done[0]), .o_pass_cnt(pass_cnt[0]), .o_err(err[0]), .o_err_cnt(err_cnt[0])
    );

    ram_rd_check #(.RD_LAT(2), .ERR_W(8)) u_dut_l2 (
        .i_clk(clk), .i_rst(rst), .i_rd_flag(rd_flag),
        .o_ram_rd_en(rd_en[1]), .o_ram_rd_addr(rd_addr[1]), .i_ram_rd_data(rd_data[1]),
        .o_rd_valid(rd_valid[1]), .o_rd_data_q(rd_data_q[1]), .o_rd_addr_q(rd_addr_q[1]),
        .o_pass_done(pass_done[1]), .o_pass_cnt(pass_cnt[1]), .o_err(err[1]), .o_err_cnt(err_cnt[1])
    );

    // RAM model: one shared array, a 1-cycle port for the first DUT and a 2-cycle port for the second.
    logic [7:0] mem [64];
    logic [7:0] ram1_q = 8'd0;
    logic [7:0] ram2_a = 8'd0;
    logic [7:0] ram2_b = 8'd0;
    always @(posedge clk) begin
        if (rd_en[0]) ram1_q <= mem[rd_addr[0]];
        if (rd_en[1]) ram2_a <= mem[rd_addr[1]];
        ram2_b <= ram2_a;
    end
    assign rd_data[0] = ram1_q;
    assign rd_data[1] = ram2_b;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 reading, 2 draining; m_n counts words issued since the sweep began.
    int m_mode [2];
    int m_n    [2];
    int m_left [2];
    int hist   [2][4];
    int m_valid[2];
    int m_dq   [2];
    int m_aq   [2];
    int m_done [2];
    int m_pass [2];
    int m_errf [2];
    int m_err  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_n[k] = 0; m_left[k] = 0;
            for (int j = 0; j < 4; j++) hist[k][j] = -1;
            m_valid[k] = 0; m_dq[k] = 0; m_aq[k] = 0; m_done[k] = 0;
            m_pass[k] = 0; m_errf[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic f);
        int lat;
        int r;
        lat = k + 1;
        case (m_mode[k])
            0: if (f) begin m_mode[k] = 1; m_n[k] = 0; end
            1: if (f) m_n[k]++; else begin m_mode[k] = 2; m_left[k] = lat; end
            default: begin
                m_left[k]--;
                if (m_left[k] == 0) begin m_mode[k] = 0; m_n[k] = 0; end
            end
        endcase
        for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = (m_mode[k] == 1) ? (m_n[k] % 64) : -1;
        // Word requested lat+1 cycles ago is the one whose check is visible now.
        r = hist[k][lat+1];
        m_valid[k] = 0;
        m_done[k]  = 0;
        if (r >= 0) begin
            m_valid[k] = 1;
            m_aq[k] = r;
            m_dq[k] = int'(mem[r]);
            if (int'(mem[r]) != r) begin
                m_errf[k] = 1;
                if (m_err[k] < 255) m_err[k]++;
            end
            if (r == 63) begin
                m_done[k] = 1;
                if (m_pass[k] < 255) m_pass[k]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d_rd_en", k + 1),     32'(rd_en[k]),     32'(m_mode[k] == 1));
            check($sformatf("L%0d_rd_addr", k + 1),   32'(rd_addr[k]),   32'(m_n[k] % 64));
            check($sformatf("L%0d_rd_valid", k + 1),  32'(rd_valid[k]),  32'(m_valid[k]));
            check($sformatf("L%0d_rd_data_q", k + 1), 32'(rd_data_q[k]), 32'(m_dq[k]));
            check($sformatf("L%0d_rd_addr_q", k + 1), 32'(rd_addr_q[k]), 32'(m_aq[k]));
            check($sformatf("L%0d_pass_done", k + 1), 32'(pass_done[k]), 32'(m_done[k]));
            check($sformatf("L%0d_pass_cnt", k + 1),  32'(pass_cnt[k]),  32'(m_pass[k]));
            check($sformatf("L%0d_err", k + 1),       32'(err[k]),       32'(m_errf[k]));
            check($sformatf("L%0d_err_cnt", k + 1),   32'(err_cnt[k]),   32'(m_err[k]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k, rd_flag);
        compare_all();
    endtask

    task automatic wait_addr(input int a);
        int guard;
        guard = 0;
        while (!(m_mode[0] == 1 && (m_n[0] % 64) == a)) begin
            tick();
            guard++;
            if (guard > 200) begin
                check("wait_addr_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_flag = 1'b0;
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();

        // Clean sweep: three full passes with wrap-around.
        rd_flag = 1'b1;
        repeat (3 * 64 + 10) tick();

        // Drop the flag at address 40, then restart from 0.
        wait_addr(40);
        rd_flag = 1'b0;
        repeat (8) tick();
        check("L1_idle_addr", 32'(rd_addr[0]), 32'd0);
        rd_flag = 1'b1;
        repeat (70) tick();

        // Corrupt addresses 17 and 63 while both readers are idle.
        rd_flag = 1'b0;
        repeat (8) tick();
        mem[17] = 8'hFF;
        mem[63] = 8'hFF;
        rd_flag = 1'b1;
        repeat (2 * 64 + 10) tick();

        // Asynchronous reset in the middle of a pass.
        wait_addr(25);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        rst = 1'b0;
        rd_flag = 1'b0;
        repeat (5) tick();

        // Every word wrong for five passes drives err_cnt into saturation.
        for (int a = 0; a < 64; a++) mem[a] = 8'(a) ^ 8'hC0;
        rd_flag = 1'b1;
        repeat (5 * 64 + 10) tick();
        check("L1_err_cnt_sat", 32'(err_cnt[0]), 32'd255);
        check("L2_err_cnt_sat", 32'(err_cnt[1]), 32'd255);

        // Random flag activity over sparsely corrupted memory.
        rd_flag = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 64; a++) mem[a] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(a);
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) rd_flag = ~rd_flag;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
